// File: rtl/decode_issue_queue.sv
// decode_issue_queue: in-order decode-to-execute issue queue with a load-use scoreboard
module decode_issue_queue #(
    parameter int WORD         = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int INSTR_WIDTH  = 16,
    parameter int QUEUE_DEPTH  = 4,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [WORD-1:0]        pc_i,
    input  logic [ADDR_WIDTH-1:0]  src1_addr_i,
    input  logic [ADDR_WIDTH-1:0]  src2_addr_i,
    input  logic                   src1_used_i,
    input  logic                   src2_used_i,
    input  logic [ADDR_WIDTH-1:0]  dest_addr_i,
    input  logic                   is_load_i,
    output logic                   issue_valid_o,
    input  logic                   exe_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [WORD-1:0]        pc_o,
    output logic [ADDR_WIDTH-1:0]  src1_addr_o,
    output logic [ADDR_WIDTH-1:0]  src2_addr_o,
    output logic [ADDR_WIDTH-1:0]  dest_addr_o,
    output logic                   is_load_o,
    input  logic                   flush_pipeline_i,
    output logic                   hazard_stall_o,
    output logic [WORD-1:0]        stall_cycles_o
);
    localparam int PW   = $clog2(QUEUE_DEPTH);
    localparam int CW   = $clog2(QUEUE_DEPTH + 1);
    localparam int BW   = $clog2(LOAD_LATENCY + 1);
    localparam int NREG = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [WORD-1:0]        pc;
        logic [ADDR_WIDTH-1:0]  src1;
        logic                   src1_used;
        logic [ADDR_WIDTH-1:0]  src2;
        logic                   src2_used;
        logic [ADDR_WIDTH-1:0]  dest;
        logic                   is_load;
    } entry_t;

    entry_t          mem_q [QUEUE_DEPTH];
    logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   busy_q [NREG];
    logic [BW-1:0]   busy_d [NREG];
    logic [WORD-1:0] stall_q, stall_d;
    entry_t          head;
    logic            empty, hazard, push, issue;

    assign head           = mem_q[rptr_q];
    assign empty          = count_q == '0;
    assign hazard         = (head.src1_used && busy_q[head.src1] != '0) || (head.src2_used && busy_q[head.src2] != '0);
    assign push_ready_o   = count_q != CW'(QUEUE_DEPTH) && !flush_pipeline_i;
    assign issue_valid_o  = !empty && !hazard && !flush_pipeline_i;
    assign hazard_stall_o = !empty && hazard && !flush_pipeline_i;
    assign push           = push_valid_i && push_ready_o;
    assign issue          = issue_valid_o && exe_ready_i;
    assign instr_o        = head.instr;
    assign pc_o           = head.pc;
    assign src1_addr_o    = head.src1;
    assign src2_addr_o    = head.src2;
    assign dest_addr_o    = head.dest;
    assign is_load_o      = head.is_load;
    assign stall_cycles_o = stall_q;

    // next state: pointers/count collapse on flush; scoreboard reload on load issue beats decrement
    always_comb begin
        rptr_d  = flush_pipeline_i ? '0 : issue ? rptr_q + PW'(1) : rptr_q;
        wptr_d  = flush_pipeline_i ? '0 : push ? wptr_q + PW'(1) : wptr_q;
        count_d = flush_pipeline_i ? '0 : count_q + CW'(push) - CW'(issue);
        stall_d = hazard_stall_o && stall_q != '1 ? stall_q + WORD'(1) : stall_q;
        for (int r = 0; r < NREG; r++)
            busy_d[r] = issue && head.is_load && head.dest == ADDR_WIDTH'(r) ? BW'(LOAD_LATENCY)
                                                                              : busy_q[r] - BW'(busy_q[r] != '0);
    end

    // control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
            busy_q  <= '{default: '0};
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
        end
    end

    // entry storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= '{instr: instr_i, pc: pc_i, src1: src1_addr_i, src1_used: src1_used_i,
                               src2: src2_addr_i, src2_used: src2_used_i, dest: dest_addr_i, is_load: is_load_i};
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: queue-model checker plus directed scenarios for decode_issue_queue
module tb_decode_issue_queue;
    localparam int LAT = 1;

    logic        clk = 0, reset_i = 0, push_valid_i = 0, exe_ready_i = 0, flush_pipeline_i = 0;
    logic        src1_used_i = 0, src2_used_i = 0, is_load_i = 0;
    logic [15:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [3:0]  src1_addr_i = '0, src2_addr_i = '0, dest_addr_i = '0;

    logic        o0_pr, o0_iv, o0_hs, o0_ld, o1_pr, o1_iv, o1_hs, o1_ld;
    logic [15:0] o0_instr, o1_instr;
    logic [31:0] o0_pc, o0_sc, o1_pc, o1_sc;
    logic [3:0]  o0_s1, o0_s2, o0_d, o1_s1, o1_s2, o1_d;

    int n_chk = 0, n_fail = 0;

    decode_issue_queue #(.LOAD_LATENCY(1)) u0 (
        .clk_i(clk), .reset_i(reset_i), .push_valid_i(push_valid_i), .push_ready_o(o0_pr),
        .instr_i(instr_i), .pc_i(pc_i), .src1_addr_i(src1_addr_i), .src2_addr_i(src2_addr_i),
        .src1_used_i(src1_used_i), .src2_used_i(src2_used_i), .dest_addr_i(dest_addr_i), .is_load_i(is_load_i),
        .issue_valid_o(o0_iv), .exe_ready_i(exe_ready_i), .instr_o(o0_instr), .pc_o(o0_pc),
        .src1_addr_o(o0_s1), .src2_addr_o(o0_s2), .dest_addr_o(o0_d), .is_load_o(o0_ld),
        .flush_pipeline_i(flush_pipeline_i), .hazard_stall_o(o0_hs), .stall_cycles_o(o0_sc)
    );

    decode_issue_queue #(.LOAD_LATENCY(3)) u1 (
        .clk_i(clk), .reset_i(reset_i), .push_valid_i(push_valid_i), .push_ready_o(o1_pr),
        .instr_i(instr_i), .pc_i(pc_i), .src1_addr_i(src1_addr_i), .src2_addr_i(src2_addr_i),
        .src1_used_i(src1_used_i), .src2_used_i(src2_used_i), .dest_addr_i(dest_addr_i), .is_load_i(is_load_i),
        .issue_valid_o(o1_iv), .exe_ready_i(exe_ready_i), .instr_o(o1_instr), .pc_o(o1_pc),
        .src1_addr_o(o1_s1), .src2_addr_o(o1_s2), .dest_addr_o(o1_d), .is_load_o(o1_ld),
        .flush_pipeline_i(flush_pipeline_i), .hazard_stall_o(o1_hs), .stall_cycles_o(o1_sc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [31:0] pc;
        logic [3:0]  s1, s2, d;
        bit          s1u, s2u, ld;
    } ent_t;

    ent_t   q[$];
    ent_t   h, e;
    int     busy[16];
    longint stalls;
    bit     started = 0, emp, hz, e_pr, e_iv, e_hs, iss;

    // model of the L=1 instance: an in-order list of entries plus per-register remaining busy cycles
    initial begin
        forever begin
            @(negedge clk);
            emp = q.size() == 0;
            hz  = 0;
            if (!emp) hz = (q[0].s1u && busy[q[0].s1] > 0) || (q[0].s2u && busy[q[0].s2] > 0);
            e_pr = q.size() != 4 && !flush_pipeline_i;
            e_iv = !emp && !hz && !flush_pipeline_i;
            e_hs = !emp && hz && !flush_pipeline_i;
            if (started) begin
                chk("m_push_ready", 64'(o0_pr), 64'(e_pr));
                chk("m_issue_valid", 64'(o0_iv), 64'(e_iv));
                chk("m_hazard_stall", 64'(o0_hs), 64'(e_hs));
                chk("m_stall_cycles", 64'(o0_sc), 64'(stalls));
                if (!emp) begin
                    chk("m_pc", 64'(o0_pc), 64'(q[0].pc));
                    chk("m_instr", 64'(o0_instr), 64'(q[0].instr));
                    chk("m_src1", 64'(o0_s1), 64'(q[0].s1));
                    chk("m_src2", 64'(o0_s2), 64'(q[0].s2));
                    chk("m_dest", 64'(o0_d), 64'(q[0].d));
                    chk("m_is_load", 64'(o0_ld), 64'(q[0].ld));
                end
            end
            @(posedge clk);
            if (reset_i) begin
                q.delete();
                foreach (busy[r]) busy[r] = 0;
                stalls  = 0;
                started = 1;
            end else if (started) begin
                iss = e_iv && exe_ready_i;
                if (iss) h = q.pop_front();
                for (int r = 0; r < 16; r++)
                    if (iss && h.ld && h.d == r) busy[r] = LAT;
                    else if (busy[r] > 0) busy[r]--;
                if (e_pr && push_valid_i) begin
                    e.instr = instr_i; e.pc = pc_i; e.s1 = src1_addr_i; e.s2 = src2_addr_i; e.d = dest_addr_i;
                    e.s1u = src1_used_i; e.s2u = src2_used_i; e.ld = is_load_i;
                    q.push_back(e);
                end
                if (flush_pipeline_i) q.delete();
                if (e_hs) stalls++;
            end
        end
    end

    task automatic drive(input bit rst, input bit pv, input logic [31:0] pc, input logic [3:0] s1, input bit s1u,
                         input logic [3:0] s2, input bit s2u, input logic [3:0] d, input bit ld, input bit er, input bit fl);
        @(posedge clk);
        #1;
        reset_i = rst; push_valid_i = pv; pc_i = pc; instr_i = pc[15:0] ^ 16'hA5A5;
        src1_addr_i = s1; src1_used_i = s1u; src2_addr_i = s2; src2_used_i = s2u;
        dest_addr_i = d; is_load_i = ld; exe_ready_i = er; flush_pipeline_i = fl;
        @(negedge clk);
    endtask

    task automatic idle(input bit er);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, er, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [3:0] s1, input bit s1u, input logic [3:0] s2,
                        input bit s2u, input logic [3:0] d, input bit ld, input bit er);
        drive(0, 1, pc, s1, s1u, s2, s2u, d, ld, er, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        do_reset();
        idle(0);
        chk("rst_push_ready", 64'(o0_pr), 64'd1);
        chk("rst_issue_valid", 64'(o0_iv), 64'd0);
        chk("rst_hazard", 64'(o0_hs), 64'd0);
        chk("rst_stall_cycles", 64'(o0_sc), 64'd0);

        // fill four independent entries with EXE stalled
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4 * i), 1, 0, 2, 0, 4'(4 + i), 0, 0);
            if (i == 0) chk("no_bypass", 64'(o0_iv), 64'd0);
        end
        push(32'h110, 1, 0, 2, 0, 8, 0, 1);
        chk("full_push_ready", 64'(o0_pr), 64'd0);
        chk("full_issue_valid", 64'(o0_iv), 64'd1);
        chk("order_pc0", 64'(o0_pc), 64'h100);
        push(32'h110, 1, 0, 2, 0, 8, 0, 1);
        chk("after_full_ready", 64'(o0_pr), 64'd1);
        chk("order_pc1", 64'(o0_pc), 64'h104);
        push(32'h114, 1, 0, 2, 0, 9, 0, 1);
        chk("order_pc2", 64'(o0_pc), 64'h108);
        push(32'h118, 1, 0, 2, 0, 10, 0, 1);
        chk("order_pc3", 64'(o0_pc), 64'h10C);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("wrap_pc", 64'(o0_pc), 64'h110 + 64'(4 * i));
        end
        idle(1);
        chk("drained", 64'(o0_iv), 64'd0);

        // load r3 then a reader of r3
        do_reset();
        push(32'h300, 0, 0, 0, 0, 3, 1, 1);
        push(32'h304, 3, 1, 0, 0, 8, 0, 1);
        chk("load_issue", 64'(o0_pc), 64'h300);
        idle(1);
        chk("l1_stall", 64'(o0_hs), 64'd1);
        chk("l1_blocked", 64'(o0_iv), 64'd0);
        chk("l3_stall_a", 64'(o1_hs), 64'd1);
        idle(1);
        chk("l1_dep_issue", 64'(o0_iv), 64'd1);
        chk("l1_dep_pc", 64'(o0_pc), 64'h304);
        chk("l1_stall_cnt", 64'(o0_sc), 64'd1);
        chk("l3_stall_b", 64'(o1_hs), 64'd1);
        idle(1);
        chk("l3_stall_c", 64'(o1_hs), 64'd1);
        idle(1);
        chk("l3_dep_issue", 64'(o1_iv), 64'd1);
        chk("l3_dep_pc", 64'(o1_pc), 64'h304);
        chk("l3_dep_instr", 64'(o1_instr), 64'(16'hA6A1));
        chk("l3_dep_src1", 64'(o1_s1), 64'd3);
        chk("l3_dep_src2", 64'(o1_s2), 64'd0);
        chk("l3_dep_dest", 64'(o1_d), 64'd8);
        chk("l3_dep_ld", 64'(o1_ld), 64'd0);
        chk("l3_stall_cnt", 64'(o1_sc), 64'd3);
        idle(1);

        // unused source does not stall
        push(32'h400, 0, 0, 0, 0, 3, 1, 1);
        push(32'h404, 3, 0, 5, 1, 9, 0, 1);
        idle(1);
        chk("unused_src_issue", 64'(o0_iv), 64'd1);
        chk("unused_src_pc", 64'(o0_pc), 64'h404);
        chk("unused_src_l3", 64'(o1_iv), 64'd1);
        idle(1);

        // flush with three entries queued and a load in flight
        push(32'h500, 0, 0, 0, 0, 6, 1, 0);
        push(32'h504, 6, 1, 0, 0, 10, 0, 0);
        push(32'h508, 1, 0, 2, 0, 11, 0, 0);
        push(32'h50C, 1, 0, 2, 0, 12, 0, 1);
        chk("pre_flush_load", 64'(o0_pc), 64'h500);
        drive(0, 1, 32'h510, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("flush_no_issue", 64'(o0_iv), 64'd0);
        chk("flush_no_push", 64'(o0_pr), 64'd0);
        chk("flush_no_hazard", 64'(o0_hs), 64'd0);
        push(32'h600, 6, 1, 0, 0, 13, 0, 1);
        chk("post_flush_ready", 64'(o0_pr), 64'd1);
        chk("post_flush_empty", 64'(o0_iv), 64'd0);
        idle(1);
        chk("post_flush_issue", 64'(o0_iv), 64'd1);
        chk("post_flush_pc", 64'(o0_pc), 64'h600);
        chk("l3_busy_survives", 64'(o1_hs), 64'd1);
        idle(1);
        chk("l3_busy_expires", 64'(o1_iv), 64'd1);
        chk("l3_busy_pc", 64'(o1_pc), 64'h600);
        idle(1);

        // reset during a hazard stall
        push(32'h700, 0, 0, 0, 0, 3, 1, 1);
        push(32'h704, 3, 1, 0, 0, 14, 0, 1);
        idle(1);
        chk("pre_reset_stall", 64'(o0_hs), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("mid_rst_issue_valid", 64'(o0_iv), 64'd0);
        chk("mid_rst_hazard", 64'(o0_hs), 64'd0);
        chk("mid_rst_push_ready", 64'(o0_pr), 64'd1);
        chk("mid_rst_stall_cnt", 64'(o0_sc), 64'd0);
        chk("mid_rst_l3_stall_cnt", 64'(o1_sc), 64'd0);
        chk("mid_rst_l3_ready", 64'(o1_pr), 64'd1);
        chk("mid_rst_l3_valid", 64'(o1_iv), 64'd0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised decode-to-execute issue stage that decouples fetch from execute. It buffers up to `QUEUE_DEPTH` decoded instructions and issues them in order to EXE. A per-register scoreboard enforces a configurable load-use stall (`LOAD_LATENCY`). It flushes on branch redirect. It sits between the address decoder/register-read logic and the decode/execute pipeline register, and supersedes the single-entry load-use stall path.

## Interface
Parameters:
- `WORD`, 32, data/PC width
- `ADDR_WIDTH`, 4, register address width
- `INSTR_WIDTH`, 16, instruction payload width
- `QUEUE_DEPTH`, 4, entries; power of two, ≥2
- `LOAD_LATENCY`, 1, cycles a load's destination stays busy after issue; ≥1

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  clock
  - `reset_i`  in  1  synchronous active-high reset
- Push side (from decode):
  - `push_valid_i`  in  1  decode presents an entry
  - `push_ready_o`  out  1  queue can accept; push occurs when `push_valid_i & push_ready_o`
  - `instr_i`  in  INSTR_WIDTH  instruction
  - `pc_i`  in  WORD  program counter
  - `src1_addr_i`, `src2_addr_i`  in  ADDR_WIDTH  source registers
  - `src1_used_i`, `src2_used_i`  in  1  source is actually read
  - `dest_addr_i`  in  ADDR_WIDTH  destination register
  - `is_load_i`  in  1  instruction is a memory read
- Issue side (to EXE):
  - `issue_valid_o`  out  1  head entry issuable
  - `exe_ready_i`  in  1  EXE accepts; issue occurs when `issue_valid_o & exe_ready_i`
  - `instr_o`, `pc_o`, `src1_addr_o`, `src2_addr_o`, `dest_addr_o`, `is_load_o`  out  (as inputs)  head-entry fields
- Control and status:
  - `flush_pipeline_i`  in  1  branch redirect; discard all queued entries
  - `hazard_stall_o`  out  1  head valid but blocked by scoreboard
  - `stall_cycles_o`  out  WORD  saturating count of `hazard_stall_o` cycles

## Operation
- Storage: circular buffer with read pointer, write pointer, and occupancy count.
  - Pointer width `$clog2(QUEUE_DEPTH)`; pointers wrap modulo depth.
  - Count width `$clog2(QUEUE_DEPTH+1)`.
- `push_ready_o = (count != QUEUE_DEPTH) & ~flush_pipeline_i`.
  - When full, push is refused even if an issue happens in the same cycle (no same-cycle slot reuse).
- Head fields drive outputs directly from storage.
  - When the queue is empty, output fields are don't-care and `issue_valid_o` = 0.
- Scoreboard: one busy counter per register, `2**ADDR_WIDTH` counters, width `$clog2(LOAD_LATENCY+1)`.
  - Hazard if (`src1_used` & busy[src1]) | (`src2_used` & busy[src2]) for the head entry.
  - `issue_valid_o = ~empty & ~hazard & ~flush_pipeline_i`.
  - `hazard_stall_o = ~empty & hazard & ~flush_pipeline_i`.
- On issue of a load: busy[dest] loads `LOAD_LATENCY`. Every other nonzero counter decrements by 1 each cycle.
  - If a load issues to a register whose counter is nonzero, the counter reloads to `LOAD_LATENCY`; the reload wins over the decrement.
- Simultaneous push and issue with 0 < count < depth: both happen and count is unchanged.
- Flush: in the cycle `flush_pipeline_i` = 1, there is no push and no issue.
  - The next cycle count = 0 and rptr = wptr = 0.
  - Scoreboard counters keep decrementing, because loads already issued remain in flight.
- `stall_cycles_o` increments when `hazard_stall_o` = 1 and saturates at all-ones.

## Timing
- Reset (synchronous, sampled on `clk_i` rising edge with `reset_i` = 1):
  - count, pointers, all busy counters, and `stall_cycles_o` = 0.
  - `issue_valid_o` = 0, `hazard_stall_o` = 0, `push_ready_o` = 1 (after reset deasserts).
- Reset mid-operation discards all entries and clears all busy counters with no partial issue.
- Push-to-issue latency: an entry pushed at edge N is at the head and can issue in cycle N+1 at the earliest. There is no combinational bypass from `push_valid_i` to `issue_valid_o`.
- Throughput: one push and one issue per cycle.
- Load at cycle N, dependent head at N+1: with `LOAD_LATENCY`=L, the dependent issues at cycle N+1+L.
- `issue_valid_o` must not depend combinationally on `exe_ready_i`.

## Test plan
- Reset then push 4 independent entries (pc 0x100,0x104,0x108,0x10C) with `exe_ready_i`=0 -> `push_ready_o`=0 after the 4th; enable `exe_ready_i` -> issue order 0x100..0x10C on consecutive cycles; refill while issuing confirms pointer wrap.
- L=1: load r3 followed by ADD with src1=r3 -> `hazard_stall_o`=1 for exactly 1 cycle, ADD issues 2 cycles after the load, `stall_cycles_o`=1; repeat with `LOAD_LATENCY`=3 -> 3 stall cycles.
- Load r3 then instruction reading r3 with `src1_used_i`=0 -> no stall, back-to-back issue.
- Queue holding 3 entries, assert `flush_pipeline_i` while `push_valid_i`=1 and `exe_ready_i`=1 -> nothing issued or accepted that cycle; next cycle empty, `push_ready_o`=1; a pending load's busy counter still expires on schedule.
- Full queue, simultaneous issue and `push_valid_i` -> push refused, count 4→3; next cycle push accepted.
- Assert `reset_i` during a hazard stall -> all outputs return to reset values next cycle; `stall_cycles_o`=0.
